// File: rtl/clock_vip_freq_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_vip_freq_checker_if
//  Description : Configuration and result bundle of the clock VIP frequency
//                checker. The master side drives the monitored clock and the
//                expectations. The slave side (the checker) returns its
//                measurements and flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_vip_freq_checker_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             clock_in;
  logic [CNT_W-1:0] exp_period_cyc;
  logic [CNT_W-1:0] exp_high_cyc;
  logic [CNT_W-1:0] tol_cyc;
  logic             err_clear;
  logic             clock_active;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             period_err;
  logic             duty_err;
  logic [31:0]      edge_count;

  modport master (
    output enable, clock_in, exp_period_cyc, exp_high_cyc, tol_cyc, err_clear,
    input  clock_active, meas_valid, meas_period, meas_high,
           period_err, duty_err, edge_count
  );

  modport slave (
    input  enable, clock_in, exp_period_cyc, exp_high_cyc, tol_cyc, err_clear,
    output clock_active, meas_valid, meas_period, meas_high,
           period_err, duty_err, edge_count
  );
endinterface
`default_nettype wire

// File: rtl/clock_vip_freq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : clock_vip_freq_checker
//  Description : Passive checker for the clock VIP. It oversamples clock_in
//                with clk, measures the period and high time in clk cycles,
//                compares them with the expected values and raises sticky
//                period/duty error flags. It also detects a dead clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_vip_freq_checker #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input wire                      clk,
  input wire                      rst,
  clock_vip_freq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_ARMED      = 2'd2,
    ST_RUN        = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);

  // Unsigned distance between two counts, one bit wider so it cannot wrap.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_lat_q, high_lat_d;
  logic                   seen_fall_q, seen_fall_d;
  logic                   clock_active_q, clock_active_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]       meas_period_q, meas_period_d;
  logic [CNT_W-1:0]       meas_high_q, meas_high_d;
  logic                   period_err_q, period_err_d;
  logic                   duty_err_q, duty_err_d;
  logic [31:0]            edge_count_q, edge_count_d;

  logic w_sync;
  logic w_rise;
  logic w_fall;
  logic w_timeout;
  logic w_period_viol;
  logic w_duty_viol;
  logic w_period_set;
  logic w_duty_set;

  assign w_sync    = sync_q[SYNC_STAGES-1];
  assign w_rise    = w_sync & ~prev_q;
  assign w_fall    = ~w_sync & prev_q;
  assign w_timeout = (cnt_q >= c_timeout);

  // The high time only counts as valid if a falling edge was seen inside the period.
  assign w_period_viol = abs_diff(cnt_q, bus.exp_period_cyc) > {1'b0, bus.tol_cyc};
  assign w_duty_viol   = ~seen_fall_q |
                         (abs_diff(high_lat_q, bus.exp_high_cyc) > {1'b0, bus.tol_cyc});

  // Synchronizer shift chain and edge-detect history.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.clock_in};
    prev_d = w_sync;
  end

  // Cycles-since-rise counter and capture of the high time at the falling edge.
  always_comb begin
    cnt_d       = cnt_q;
    high_lat_d  = high_lat_q;
    seen_fall_d = seen_fall_q;
    if (!bus.enable) begin
      cnt_d       = '0;
      seen_fall_d = 1'b0;
    end else begin
      if (w_rise) begin
        cnt_d       = CNT_W'(1);
        seen_fall_d = 1'b0;
      end else if (cnt_q != c_cnt_max) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (w_fall) begin
        high_lat_d  = cnt_q;
        seen_fall_d = 1'b1;
      end
    end
  end

  // Lock-on FSM, measurement publication, edge counting and sticky errors.
  always_comb begin
    state_d        = state_q;
    clock_active_d = clock_active_q;
    meas_valid_d   = 1'b0;
    meas_period_d  = meas_period_q;
    meas_high_d    = meas_high_q;
    edge_count_d   = edge_count_q;
    w_period_set   = 1'b0;
    w_duty_set     = 1'b0;

    if (!bus.enable) begin
      // Disabling abandons any period in progress; nothing is reported for it.
      state_d        = ST_IDLE;
      clock_active_d = 1'b0;
    end else begin
      if (w_rise && (state_q != ST_IDLE)) begin
        edge_count_d = edge_count_q + 32'd1;
      end
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_FIRST;
        end
        ST_WAIT_FIRST: begin
          if (w_rise) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          // The period ending here started at an unknown phase, so it is not measured.
          if (w_rise) begin
            state_d        = ST_RUN;
            clock_active_d = 1'b1;
          end else if (w_timeout) begin
            state_d        = ST_WAIT_FIRST;
            clock_active_d = 1'b0;
          end
        end
        ST_RUN: begin
          if (w_rise) begin
            meas_valid_d  = 1'b1;
            meas_period_d = cnt_q;
            meas_high_d   = seen_fall_q ? high_lat_q : cnt_q;
            w_period_set  = w_period_viol;
            w_duty_set    = w_duty_viol;
          end else if (w_timeout) begin
            state_d        = ST_WAIT_FIRST;
            clock_active_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // A new violation wins over a simultaneous clear.
    period_err_d = (period_err_q & ~bus.err_clear) | w_period_set;
    duty_err_d   = (duty_err_q & ~bus.err_clear) | w_duty_set;
  end

  // State register for every flop in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      high_lat_q     <= '0;
      seen_fall_q    <= 1'b0;
      clock_active_q <= 1'b0;
      meas_valid_q   <= 1'b0;
      meas_period_q  <= '0;
      meas_high_q    <= '0;
      period_err_q   <= 1'b0;
      duty_err_q     <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      high_lat_q     <= high_lat_d;
      seen_fall_q    <= seen_fall_d;
      clock_active_q <= clock_active_d;
      meas_valid_q   <= meas_valid_d;
      meas_period_q  <= meas_period_d;
      meas_high_q    <= meas_high_d;
      period_err_q   <= period_err_d;
      duty_err_q     <= duty_err_d;
      edge_count_q   <= edge_count_d;
    end
  end

  assign bus.clock_active = clock_active_q;
  assign bus.meas_valid   = meas_valid_q;
  assign bus.meas_period  = meas_period_q;
  assign bus.meas_high    = meas_high_q;
  assign bus.period_err   = period_err_q;
  assign bus.duty_err     = duty_err_q;
  assign bus.edge_count   = edge_count_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_vip_freq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_vip_freq_checker
//  Description : Self-checking bench for clock_vip_freq_checker. A clock_in
//                waveform is built on clk negedges. An edge-history model
//                predicts every output cycle by cycle, and literal expectations
//                pin the key scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_vip_freq_checker;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int TMO   = 64;
  localparam int HN    = 1 << 17;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ARMED = 2;
  localparam int P_RUN   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clock_vip_freq_checker_if #(.CNT_W(CNT_W)) vif();

  clock_vip_freq_checker #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on absolute edge indices. clock_in as sampled at every clk edge is
  // kept in a history. A rise is handled SYNC edges after it was sampled.
  // Period and high time are differences between edge indices.
  bit          hist [HN];
  int          e = 0;
  int          rst_edge = -1;
  int          phase = P_IDLE;
  int          last_rise = 0;
  int          last_fall = -1;
  logic        m_ca = 1'b0, m_mv = 1'b0, m_pe = 1'b0, m_de = 1'b0;
  logic [15:0] m_mp = '0, m_mh = '0;
  logic [31:0] m_ec = '0;

  function automatic bit h(input int k);
    if (k < 0 || k <= rst_edge) return 1'b0;
    return hist[k % HN];
  endfunction

  function automatic int ad(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_step();
    bit rise, fall, sf, pv, dv;
    int cnt, hl;
    hist[e % HN] = vif.clock_in;
    pv = 1'b0;
    dv = 1'b0;
    if (rst) begin
      phase = P_IDLE; m_ca = 0; m_mv = 0; m_mp = '0; m_mh = '0;
      m_pe = 0; m_de = 0; m_ec = '0; last_rise = 0; last_fall = -1;
      rst_edge = e;
    end else begin
      rise = h(e - SYNC) && !h(e - SYNC - 1);
      fall = !h(e - SYNC) && h(e - SYNC - 1);
      m_mv = 1'b0;
      if (!vif.enable) begin
        phase = P_IDLE; m_ca = 1'b0; last_fall = -1;
      end else if (phase == P_IDLE) begin
        phase = P_WAIT;
      end else begin
        if (fall) last_fall = e;
        if (rise) begin
          m_ec++;
          cnt = e - last_rise;
          if (phase == P_WAIT) phase = P_ARMED;
          else if (phase == P_ARMED) begin
            phase = P_RUN; m_ca = 1'b1;
          end else begin
            sf   = last_fall > last_rise;
            hl   = last_fall - last_rise;
            m_mv = 1'b1;
            m_mp = 16'(cnt);
            m_mh = sf ? 16'(hl) : 16'(cnt);
            pv   = ad(cnt, int'(vif.exp_period_cyc)) > int'(vif.tol_cyc);
            dv   = !sf || (ad(hl, int'(vif.exp_high_cyc)) > int'(vif.tol_cyc));
          end
          last_rise = e;
        end else if (phase >= P_ARMED && (e - last_rise) >= TMO) begin
          phase = P_WAIT; m_ca = 1'b0;
        end
      end
      m_pe = (m_pe && !vif.err_clear) || pv;
      m_de = (m_de && !vif.err_clear) || dv;
    end
    e++;
  endtask

  task automatic compare();
    chk("clock_active", vif.clock_active, m_ca);
    chk("meas_valid",   vif.meas_valid,   m_mv);
    chk("meas_period",  vif.meas_period,  m_mp);
    chk("meas_high",    vif.meas_high,    m_mh);
    chk("period_err",   vif.period_err,   m_pe);
    chk("duty_err",     vif.duty_err,     m_de);
    chk("edge_count",   vif.edge_count,   m_ec);
  endtask

  // Advance the model at every edge and compare just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic ci, input logic clr);
    @(negedge clk);
    vif.clock_in  = ci;
    vif.err_clear = clr;
  endtask

  task automatic period(input int p, input int hi, input int clr_ph, input int clr_rate);
    for (int t = 0; t < p; t++) begin
      logic c;
      c = (t == clr_ph) || (clr_rate > 0 && $urandom_range(0, clr_rate - 1) == 0);
      tick(t < hi, c);
    end
  endtask

  task automatic set_exp(input int p, input int hi, input int tol);
    vif.exp_period_cyc = 16'(p);
    vif.exp_high_cyc   = 16'(hi);
    vif.tol_cyc        = 16'(tol);
  endtask

  initial begin
    vif.enable = 1'b0; vif.clock_in = 1'b0; vif.err_clear = 1'b0;
    set_exp(0, 0, 0);
    repeat (3) tick(1'b0, 1'b0);

    // Reset state
    chk("rst_clock_active", vif.clock_active, 0);
    chk("rst_meas_valid",   vif.meas_valid,   0);
    chk("rst_period_err",   vif.period_err,   0);
    chk("rst_edge_count",   vif.edge_count,   0);
    rst = 1'b0;

    // Nominal 10/5 clock, exact expectations
    set_exp(10, 5, 0);
    vif.enable = 1'b1;
    repeat (6) period(10, 5, -1, 0);
    chk("t1_meas_period",  vif.meas_period,  10);
    chk("t1_meas_high",    vif.meas_high,    5);
    chk("t1_clock_active", vif.clock_active, 1);
    chk("t1_period_err",   vif.period_err,   0);
    chk("t1_duty_err",     vif.duty_err,     0);

    // Period violation, clear, re-set, clear coincident with a violation
    set_exp(10, 6, 1);
    repeat (3) period(12, 6, -1, 0);
    chk("t2_period_err", vif.period_err, 1);
    chk("t2_duty_err",   vif.duty_err,   0);
    period(12, 6, 6, 0);
    chk("t2_cleared",    vif.period_err, 0);
    period(12, 6, -1, 0);
    chk("t2_reset",      vif.period_err, 1);
    period(12, 6, SYNC, 0);
    chk("t2_set_wins",   vif.period_err, 1);

    // High-time violation, including a clock high for all but one cycle
    set_exp(10, 5, 1);
    repeat (2) period(10, 7, -1, 0);
    period(10, 7, 5, 0);
    repeat (2) period(10, 7, -1, 0);
    chk("t3_duty_err",   vif.duty_err,   1);
    chk("t3_period_err", vif.period_err, 0);
    repeat (2) period(10, 9, -1, 0);
    chk("t3_stuck_high_duty", vif.duty_err, 1);

    // Enable drop mid-period
    repeat (3) tick(1'b1, 1'b0);
    vif.enable = 1'b0;
    tick(1'b1, 1'b0);
    chk("t5_clock_active", vif.clock_active, 0);
    chk("t5_meas_valid",   vif.meas_valid,   0);
    chk("t5_duty_kept",    vif.duty_err,     1);
    repeat (2) tick(1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0);
    vif.enable = 1'b1;
    repeat (4) period(10, 5, -1, 0);
    chk("t5_reenabled",    vif.clock_active, 1);
    chk("t5_duty_sticky",  vif.duty_err,     1);

    // Timeout: the rise is handled SYNC edges after sampling, then TMO cycles follow
    period(10, 5, 5, 0);
    period(10, 5, -1, 0);
    chk("t4_errs_clear", vif.duty_err, 0);
    repeat (57) tick(1'b0, 1'b0);
    chk("t4_active_before_timeout", vif.clock_active, 1);
    tick(1'b0, 1'b0);
    chk("t4_active_after_timeout",  vif.clock_active, 0);
    repeat (4) period(10, 5, -1, 0);
    chk("t4_recovered",  vif.clock_active, 1);
    chk("t4_no_period_err", vif.period_err, 0);
    chk("t4_no_duty_err",   vif.duty_err,   0);

    // Reset while running with errors set
    set_exp(20, 8, 0);
    repeat (3) period(10, 5, -1, 0);
    chk("t6_period_err_set", vif.period_err, 1);
    chk("t6_duty_err_set",   vif.duty_err,   1);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    chk("t6_rst_active",     vif.clock_active, 0);
    chk("t6_rst_period",     vif.meas_period,  0);
    chk("t6_rst_high",       vif.meas_high,    0);
    chk("t6_rst_period_err", vif.period_err,   0);
    chk("t6_rst_duty_err",   vif.duty_err,     0);
    chk("t6_rst_edge_count", vif.edge_count,   0);
    set_exp(10, 5, 0);
    repeat (2) period(10, 5, -1, 0);

    // edge_count wrap from a preloaded value
    force dut.edge_count_q = 32'hFFFF_FFFE;
    m_ec = 32'hFFFF_FFFE;
    #1;
    release dut.edge_count_q;
    repeat (4) period(10, 5, -1, 0);
    chk("t6_edge_wrap", vif.edge_count, 2);

    // Randomized segments: jittered clocks, clears, enable drops, stalls, resets
    for (int s = 0; s < 60; s++) begin
      int p, hi, n, rate, r, dp, dh;
      p    = int'($urandom_range(3, 30));
      hi   = int'($urandom_range(1, p - 1));
      dp   = int'($urandom_range(0, 4));
      dh   = int'($urandom_range(0, 4));
      set_exp(p + dp - 2, (hi + dh - 2 < 0) ? 0 : hi + dh - 2, int'($urandom_range(0, 2)));
      rate = ($urandom_range(0, 2) == 0) ? 25 : 0;
      n    = int'($urandom_range(2, 6));
      for (int i = 0; i < n; i++) begin
        int pj, hj;
        pj = p + int'($urandom_range(0, 2)) - 1;
        if (pj < 2) pj = 2;
        hj = (hi < pj) ? hi : pj - 1;
        period(pj, hj, -1, rate);
      end
      r = int'($urandom_range(0, 19));
      if (r < 3) begin
        int k;
        k = int'($urandom_range(1, p - 1));
        for (int t = 0; t < k; t++) tick(t < hi, 1'b0);
        vif.enable = 1'b0;
        repeat ($urandom_range(1, 15)) tick(1'($urandom_range(0, 1)), 1'b0);
        vif.enable = 1'b1;
      end else if (r < 5) begin
        repeat (70) tick(1'b0, 1'b0);
      end else if (r == 5) begin
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
      end
    end

    repeat (3) tick(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
